// File: rtl/fp_align_stage_pkg.sv
// fp_align_stage_pkg: FP32 field widths, shift limit and state encodings for the alignment stage.
package fp_align_stage_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MAN_W  = 27;
    localparam int SH_MAX = 26;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Denormals share the exponent of the smallest normal.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction
endpackage

// File: rtl/fp_align_stage_comp8.sv
// comp8: 8-bit unsigned exponent comparator with absolute difference.
module comp8
    import fp_align_stage_pkg::*;
(
    input  logic [EXP_W-1:0] a,
    input  logic [EXP_W-1:0] b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic [EXP_W-1:0] abs_diff
);
    assign a_lt_b   = a < b;
    assign a_eq_b   = a == b;
    assign a_gt_b   = a > b;
    assign abs_diff = a_lt_b ? b - a : a - b;
endmodule

// File: rtl/fp_align_stage.sv
// fp_align_stage: swaps FP32 operands by exponent and right-aligns the smaller mantissa
// STEP bits per cycle, keeping guard/round/sticky in the low three bits.
module fp_align_stage
    import fp_align_stage_pkg::*;
#(
    parameter int STEP   = 4,
    parameter int SH_MAX = fp_align_stage_pkg::SH_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              a_sign,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [FRAC_W-1:0] a_man,
    input  logic              b_sign,
    input  logic [EXP_W-1:0]  b_exp,
    input  logic [FRAC_W-1:0] b_man,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              big_sign,
    output logic              small_sign,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MAN_W-1:0]  big_man,
    output logic [MAN_W-1:0]  small_man,
    output logic              swapped
);
    state_t            state;
    logic [EXP_W-1:0]  a_eff, b_eff, diff;
    logic              a_lt_b;
    logic [4:0]        sh, k, rem;
    logic [MAN_W-1:0]  a_full, b_full, mask;

    assign a_eff  = eff_exp(a_exp);
    assign b_eff  = eff_exp(b_exp);
    assign a_full = {a_exp != '0, a_man, 3'b000};
    assign b_full = {b_exp != '0, b_man, 3'b000};

    comp8 u_comp (
        .a        (a_eff),
        .b        (b_eff),
        .a_lt_b   (a_lt_b),
        .a_eq_b   (),
        .a_gt_b   (),
        .abs_diff (diff)
    );

    always_comb begin
        sh   = (diff > EXP_W'(SH_MAX)) ? 5'(SH_MAX) : diff[4:0];
        k    = (rem > 5'(STEP)) ? 5'(STEP) : rem;
        mask = (MAN_W'(1) << k) - MAN_W'(1);
    end

    assign in_ready = rst_n && state == IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            big_sign   <= 1'b0;
            small_sign <= 1'b0;
            exp_out    <= '0;
            big_man    <= '0;
            small_man  <= '0;
            swapped    <= 1'b0;
            rem        <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    big_sign   <= a_lt_b ? b_sign : a_sign;
                    small_sign <= a_lt_b ? a_sign : b_sign;
                    exp_out    <= a_lt_b ? b_eff : a_eff;
                    big_man    <= a_lt_b ? b_full : a_full;
                    small_man  <= a_lt_b ? a_full : b_full;
                    swapped    <= a_lt_b;
                    rem        <= sh;
                    state      <= (sh == '0) ? DONE : SHIFT;
                    out_valid  <= sh == '0;
                end
                SHIFT: begin
                    // Bit0 is inside the mask, so an already-set sticky stays set.
                    small_man <= (small_man >> k) | MAN_W'(|(small_man & mask));
                    rem       <= rem - k;
                    if (rem == k) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_align_stage.sv
// tb_fp_align_stage: directed vector table plus backpressure, reset-abort and back-to-back sequences.
module tb_fp_align_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        a_sign = 1'b0, b_sign = 1'b0;
    logic [7:0]  a_exp = '0, b_exp = '0;
    logic [22:0] a_man = '0, b_man = '0;
    logic        in_ready, out_valid, big_sign, small_sign, swapped;
    logic [7:0]  exp_out;
    logic [26:0] big_man, small_man;

    int total = 0, bad = 0;

    typedef struct packed {
        logic        as;
        logic [7:0]  ae;
        logic [22:0] am;
        logic        bs;
        logic [7:0]  be;
        logic [22:0] bm;
        logic        x_bs;
        logic        x_ss;
        logic [7:0]  x_exp;
        logic [26:0] x_big;
        logic [26:0] x_small;
        logic        x_sw;
        logic [7:0]  x_lat;
    } vec_t;

    vec_t vecs [9];

    fp_align_stage #(.STEP(4), .SH_MAX(26)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .a_exp(a_exp), .a_man(a_man),
        .b_sign(b_sign), .b_exp(b_exp), .b_man(b_man),
        .out_valid(out_valid), .out_ready(out_ready),
        .big_sign(big_sign), .small_sign(small_sign), .exp_out(exp_out),
        .big_man(big_man), .small_man(small_man), .swapped(swapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        a_sign = v.as; a_exp = v.ae; a_man = v.am;
        b_sign = v.bs; b_exp = v.be; b_man = v.bm;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk({tag, " in_ready timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Called right after the accept edge; counts edges until out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_out(input vec_t v, input string tag);
        chk({tag, " out_valid"},  32'(out_valid),  32'd1);
        chk({tag, " big_sign"},   32'(big_sign),   32'(v.x_bs));
        chk({tag, " small_sign"}, 32'(small_sign), 32'(v.x_ss));
        chk({tag, " exp_out"},    32'(exp_out),    32'(v.x_exp));
        chk({tag, " big_man"},    32'(big_man),    32'(v.x_big));
        chk({tag, " small_man"},  32'(small_man),  32'(v.x_small));
        chk({tag, " swapped"},    32'(swapped),    32'(v.x_sw));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        wait_ready(tag);
        drive(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        chk({tag, " latency"}, 32'(lat), 32'(v.x_lat));
        check_out(v, tag);
    endtask

    initial begin
        int lat;
        logic [26:0] held;
        //          as ae      am          bs be      bm          xbs xss xexp    xbig          xsmall        xsw lat
        vecs[0] = '{1'b0, 8'd34,  23'h0,      1'b0, 8'd27,  23'h400001, 1'b0, 1'b0, 8'd34,  27'h4000000, 27'h00C0001, 1'b0, 8'd3};
        vecs[1] = '{1'b0, 8'd30,  23'h1,      1'b1, 8'd30,  23'h2,      1'b0, 1'b1, 8'd30,  27'h4000008, 27'h4000010, 1'b0, 8'd1};
        vecs[2] = '{1'b1, 8'd0,   23'h1,      1'b0, 8'd128, 23'h0,      1'b0, 1'b1, 8'd128, 27'h4000000, 27'h0000001, 1'b1, 8'd8};
        vecs[3] = '{1'b0, 8'd10,  23'h0,      1'b0, 8'd14,  23'h0,      1'b0, 1'b0, 8'd14,  27'h4000000, 27'h0400000, 1'b1, 8'd2};
        vecs[4] = '{1'b0, 8'd100, 23'h7FFFFF, 1'b0, 8'd99,  23'h7FFFFF, 1'b0, 1'b0, 8'd100, 27'h7FFFFF8, 27'h3FFFFFC, 1'b0, 8'd2};
        vecs[5] = '{1'b0, 8'd1,   23'h0,      1'b1, 8'd27,  23'h0,      1'b1, 1'b0, 8'd27,  27'h4000000, 27'h0000001, 1'b1, 8'd8};
        vecs[6] = '{1'b0, 8'd0,   23'h3,      1'b1, 8'd0,   23'h5,      1'b0, 1'b1, 8'd1,   27'h0000018, 27'h0000028, 1'b0, 8'd1};
        vecs[7] = '{1'b0, 8'd1,   23'h123456, 1'b0, 8'd255, 23'h0,      1'b0, 1'b0, 8'd255, 27'h4000000, 27'h0000001, 1'b1, 8'd8};
        vecs[8] = '{1'b0, 8'd50,  23'h0,      1'b0, 8'd45,  23'h3,      1'b0, 1'b0, 8'd50,  27'h4000000, 27'h0200001, 1'b0, 8'd3};

        repeat (3) tick();
        chk("rst in_ready",  32'(in_ready),  32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst small_man", 32'(small_man), 32'd0);
        chk("rst big_man",   32'(big_man),   32'd0);
        chk("rst exp_out",   32'(exp_out),   32'd0);
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d release", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: DONE holds while out_ready is low.
        out_ready = 1'b0;
        run_vec(vecs[0], "bp");
        held = small_man;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold small", 32'(small_man), 32'(held));
            chk("bp in_ready",   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp done valid", 32'(out_valid), 32'd0);
        chk("bp in_ready after", 32'(in_ready), 32'd1);

        // Reset during the second SHIFT cycle of the long-shift case.
        wait_ready("rst-abort");
        drive(vecs[2]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort in_ready low", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready",  32'(in_ready),  32'd1);
        chk("abort small_man", 32'(small_man), 32'd0);
        chk("abort exp_out",   32'(exp_out),   32'd0);
        run_vec(vecs[0], "after-abort");
        tick();

        // Back-to-back: in_valid stays high; second op waits for DONE->IDLE.
        wait_ready("b2b");
        drive(vecs[0]);
        in_valid = 1'b1;
        tick();
        drive(vecs[1]);
        wait_valid(lat);
        chk("b2b first latency", 32'(lat), 32'd3);
        check_out(vecs[0], "b2b first");
        chk("b2b in_ready in DONE", 32'(in_ready), 32'd0);
        tick();
        chk("b2b idle in_ready", 32'(in_ready), 32'd1);
        chk("b2b idle valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check_out(vecs[1], "b2b second");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
